// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the CP0 TLB-management sequencer.
//   TLB_LINE_NUM      : number of TLB entries
//   LOG2_TLB_LINE_NUM : TLB index width
//   INDEX_BITS        : width of the CP0 Index register / tlb Index_out
//   tlb_op_e          : TLB instruction encoding carried on op_type
//   op_state_e        : sequencer FSM states
package tlb_op_ctrl_pkg;

  localparam int unsigned TLB_LINE_NUM      = 8;
  localparam int unsigned LOG2_TLB_LINE_NUM = 3;
  localparam int unsigned INDEX_BITS        = 32;

  typedef enum logic [1:0] {
    TLBOP_P  = 2'b00,
    TLBOP_R  = 2'b01,
    TLBOP_WI = 2'b10,
    TLBOP_WR = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FIN
  } op_state_e;

endpackage

// File: rtl/tlb_op_ctrl_random_ctr.sv
// CP0 Random register: counts down from TLB_LINE_NUM-1 to Wired, then wraps.
//   clk, rst  : clock, asynchronous active-high reset
//   wired_in  : current CP0 Wired value (lower bound of the count)
//   wired_we  : Wired being written; restarts the count at the top
//   hold      : freeze the count (keeps the TLBWR index stable)
//   random    : current Random value
module tlb_random_ctr
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned TLB_LINE_NUM      = tlb_op_ctrl_pkg::TLB_LINE_NUM,
  parameter int unsigned LOG2_TLB_LINE_NUM = tlb_op_ctrl_pkg::LOG2_TLB_LINE_NUM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LOG2_TLB_LINE_NUM-1:0] wired_in,
  input  logic                         wired_we,
  input  logic                         hold,
  output logic [LOG2_TLB_LINE_NUM-1:0] random
);

  localparam logic [LOG2_TLB_LINE_NUM-1:0] TOP = LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);

  // Reaching 0 below Wired (Wired raised without wired_we) also wraps to the
  // top so the count stays modulo TLB_LINE_NUM for non-power-of-two sizes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      random <= TOP;
    else if (wired_we)
      random <= TOP;
    else if (hold)
      random <= random;
    else if (random == wired_in)
      random <= TOP;
    else if (random == '0)
      random <= TOP;
    else
      random <= random - LOG2_TLB_LINE_NUM'(1);
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR issued from M stage.
//   op_valid/op_type/flushM : M-stage instruction and flush
//   op_busy/op_done         : stall request and one-cycle completion pulse
//   tlbp/tlbr/tlbwi/tlbwr   : one-cycle command strobes to the tlb block
//   tlb_index_in            : tlb probe result (bit31 = miss)
//   index_we/index_wdata    : CP0 Index write-back (TLBP)
//   entry_we                : CP0 EntryHi/PageMask/EntryLo write-back (TLBR)
//   flush_fetch             : refetch request after a TLB write
//   wired_in/wired_we       : CP0 Wired value and write strobe
//   random_out              : CP0 Random, zero-extended
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int unsigned TLB_LINE_NUM      = tlb_op_ctrl_pkg::TLB_LINE_NUM,
  parameter int unsigned LOG2_TLB_LINE_NUM = tlb_op_ctrl_pkg::LOG2_TLB_LINE_NUM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  input  logic [1:0]                   op_type,
  input  logic                         flushM,
  output logic                         op_busy,
  output logic                         op_done,
  output logic                         tlbp,
  output logic                         tlbr,
  output logic                         tlbwi,
  output logic                         tlbwr,
  input  logic [INDEX_BITS-1:0]        tlb_index_in,
  output logic                         index_we,
  output logic [INDEX_BITS-1:0]        index_wdata,
  output logic                         entry_we,
  output logic                         flush_fetch,
  input  logic [LOG2_TLB_LINE_NUM-1:0] wired_in,
  input  logic                         wired_we,
  output logic [31:0]                  random_out
);

  op_state_e                    state_q, state_d;
  tlb_op_e                      op_q;
  logic                         accept;
  logic [LOG2_TLB_LINE_NUM-1:0] random_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= TLBOP_P;
      index_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        op_q <= tlb_op_e'(op_type);
      if (state_q == ST_ISSUE && op_q == TLBOP_P)
        index_wdata <= tlb_index_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    op_busy     = 1'b0;
    op_done     = 1'b0;
    tlbp        = 1'b0;
    tlbr        = 1'b0;
    tlbwi       = 1'b0;
    tlbwr       = 1'b0;
    index_we    = 1'b0;
    entry_we    = 1'b0;
    flush_fetch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept  = op_valid & ~flushM;
        op_busy = accept;
        if (accept)
          state_d = ST_ISSUE;
      end
      // flushM is ignored from here on: the op is committed.
      ST_ISSUE: begin
        op_busy = 1'b1;
        state_d = ST_FIN;
        case (op_q)
          TLBOP_P:  tlbp  = 1'b1;
          TLBOP_R:  tlbr  = 1'b1;
          TLBOP_WI: tlbwi = 1'b1;
          default:  tlbwr = 1'b1;
        endcase
      end
      ST_FIN: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
        case (op_q)
          TLBOP_P: index_we    = 1'b1;
          TLBOP_R: entry_we    = 1'b1;
          default: flush_fetch = 1'b1;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  tlb_random_ctr #(
    .TLB_LINE_NUM      (TLB_LINE_NUM),
    .LOG2_TLB_LINE_NUM (LOG2_TLB_LINE_NUM)
  ) u_random (
    .clk      (clk),
    .rst      (rst),
    .wired_in (wired_in),
    .wired_we (wired_we),
    .hold     (state_q == ST_ISSUE),
    .random   (random_q)
  );

  assign random_out = {{(32 - LOG2_TLB_LINE_NUM){1'b0}}, random_q};

endmodule
